codec_serializer: RTL

- Downstream consumer of the dynamics stage's mixed output.
- Accepts one 16-bit signed sample per `new_sample` strobe and buffers it in a one-deep pending register.
- Serializes each sample MSB-first onto a left-justified stereo audio-codec link (`bclk`/`lrclk`/`sdata`), with the same sample sent on both channels.
- Raises `sample_req` at each frame boundary so the upstream stage can pace sample production.

---
 rtl/codec_serializer_pkg.sv | 18 +
 rtl/codec_serializer_bclk_gen.sv | 33 +++
 rtl/codec_serializer.sv | 109 ++++++++++
 3 files changed

// File: rtl/codec_serializer_pkg.sv
// Shared audio constants and the frame-sample source encoding used by the codec serializer.
package codec_serializer_pkg;

    localparam int SAMPLE_WIDTH = 16;
    localparam int FRAME_BITS   = 2 * SAMPLE_WIDTH;

    // Where the sample for a new frame comes from.
    typedef enum logic [1:0] {
        SRC_PENDING,
        SRC_LAST,
        SRC_BYPASS
    } sample_src_e;

    function automatic int frame_bits(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/codec_serializer_bclk_gen.sv
// Bit-clock generator: divides clk by 2*BCLK_DIV and flags the cycle whose edge drops bclk.
module bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic bclk,
    output logic fall_evt
);

    localparam int CW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic          wrap;

    assign wrap     = (div_cnt == CW'(BCLK_DIV - 1));
    // High during the cycle whose rising clk edge takes bclk from 1 to 0.
    assign fall_evt = wrap && bclk;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/codec_serializer.sv
// Left-justified stereo codec serializer with a one-deep pending sample buffer.
module codec_serializer
    import codec_serializer_pkg::*;
#(
    parameter int SAMPLE_WIDTH = codec_serializer_pkg::SAMPLE_WIDTH,
    parameter int BCLK_DIV     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                           new_sample,
    output logic                           sample_req,
    output logic                           bclk,
    output logic                           lrclk,
    output logic                           sdata,
    output logic                           overflow,
    output logic                           underrun
);

    localparam int FRAME = frame_bits(SAMPLE_WIDTH);
    localparam int CNT_W = $clog2(FRAME);

    logic                    fall_evt;
    logic [CNT_W-1:0]        bit_cnt;
    logic [CNT_W-1:0]        bit_cnt_next;
    logic [FRAME-1:0]        shreg;
    logic [SAMPLE_WIDTH-1:0] pending;
    logic [SAMPLE_WIDTH-1:0] last_sample;
    logic                    pending_valid;
    logic                    frame_start;
    sample_src_e             src;
    logic [SAMPLE_WIDTH-1:0] frame_sample;

    bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk      (clk),
        .rst      (rst),
        .bclk     (bclk),
        .fall_evt (fall_evt)
    );

    assign frame_start = fall_evt && (bit_cnt == CNT_W'(FRAME - 1));
    assign sdata       = shreg[FRAME-1];

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        bit_cnt_next = bit_cnt + CNT_W'(1);
        src          = SRC_LAST;
        frame_sample = last_sample;
        if (frame_start) begin
            bit_cnt_next = '0;
        end
        if (pending_valid) begin
            src          = SRC_PENDING;
            frame_sample = pending;
        end else if (new_sample) begin
            src          = SRC_BYPASS;
            frame_sample = sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt       <= '0;
            shreg         <= '0;
            lrclk         <= 1'b0;
            pending       <= '0;
            pending_valid <= 1'b0;
            last_sample   <= '0;
            sample_req    <= 1'b0;
            overflow      <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            sample_req <= frame_start;
            overflow   <= 1'b0;
            underrun   <= 1'b0;

            if (fall_evt) begin
                bit_cnt <= bit_cnt_next;
                lrclk   <= (bit_cnt_next >= CNT_W'(SAMPLE_WIDTH));
                if (frame_start) begin
                    shreg       <= {frame_sample, frame_sample};
                    last_sample <= frame_sample;
                end else begin
                    shreg <= {shreg[FRAME-2:0], 1'b0};
                end
            end

            // A sample arriving on a frame start either refills the buffer or bypasses it.
            if (frame_start) begin
                unique case (src)
                    SRC_PENDING: begin
                        if (new_sample) pending <= sample_in;
                        else            pending_valid <= 1'b0;
                    end
                    SRC_LAST:    underrun <= 1'b1;
                    SRC_BYPASS:  ;
                    default:     ;
                endcase
            end else if (new_sample) begin
                pending       <= sample_in;
                pending_valid <= 1'b1;
                overflow      <= pending_valid;
            end
        end
    end

endmodule
